// File: rtl/fetch_buffer_stage.sv
// fetch_buffer_stage: instruction fetch stage with a small instruction buffer feeding decode.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect, redirect_pc         taken branch/jump: flush buffer and refetch from redirect_pc
//   imem_rd, imem_addr            one-cycle request strobe and address to instruction memory
//   imem_done, imem_rdata         response strobe and data for the outstanding request
//   Instruction, pc_plus2         buffer head instruction and its PC+2 (0 when empty)
//   instr_valid, decode_ready     head valid / decode consumes head
//   halted                        HALT opcode fetched, fetching stopped until a redirect
//   err                           sticky protocol error
//   fetch_cnt, squash_cnt         performance counters, live only when FETCH_PERF_EN is defined
module fetch_buffer_stage #(
   parameter int          DEPTH    = 2,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_rd,
   output logic [15:0] imem_addr,
   input  logic        imem_done,
   input  logic [15:0] imem_rdata,
   output logic [15:0] Instruction,
   output logic [15:0] pc_plus2,
   output logic        instr_valid,
   input  logic        decode_ready,
   output logic        halted,
   output logic        err,
   output logic [15:0] fetch_cnt,
   output logic [15:0] squash_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
   typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALTED} state_t;
   state_t state_q, state_d;
   logic [15:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
   logic squash_q, squash_d, err_q, err_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW:0] cnt_q, cnt_d;
   logic [15:0] instr_mem_q [DEPTH];
   logic [15:0] pcp2_mem_q [DEPTH];
   logic full, issue, pop, push, wr_en;
   always_comb begin
      full = cnt_q == FULL;
      // In RUN nothing is outstanding, so a free slot now is a reserved slot for the response.
      issue = !rst && state_q == S_RUN && !redirect && !full;
      pop = cnt_q != '0 && decode_ready && !redirect;
      push = state_q == S_WAIT && imem_done && !squash_q && !redirect;
      wr_en = push && (!full || pop);
      state_d = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d = req_pc_q;
      squash_d = squash_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
      cnt_d = (wr_en && !pop) ? cnt_q + (PW+1)'(1) : (pop && !wr_en) ? cnt_q - (PW+1)'(1) : cnt_q;
      err_d = err_q || (imem_done && state_q != S_WAIT) || (push && full && !pop);
      if (redirect) begin
         // An in-flight request whose response has not arrived yet must be dropped later.
         squash_d = state_q == S_WAIT && !imem_done;
         state_d = squash_d ? S_WAIT : S_RUN;
         fetch_pc_d = redirect_pc;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d = '0;
      end else if (issue) begin
         state_d = S_WAIT;
         req_pc_d = fetch_pc_q;
         fetch_pc_d = fetch_pc_q + 16'd2;
      end else if (state_q == S_WAIT && imem_done) begin
         squash_d = 1'b0;
         state_d = (push && imem_rdata[15:11] == 5'b00000) ? S_HALTED : S_RUN;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         fetch_pc_q <= RESET_PC;
         req_pc_q <= '0;
         squash_q <= 1'b0;
         err_q <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q <= req_pc_d;
         squash_q <= squash_d;
         err_q <= err_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) begin
         instr_mem_q[wr_ptr_q] <= imem_rdata;
         pcp2_mem_q[wr_ptr_q] <= req_pc_q + 16'd2;
      end
   end
   assign imem_rd = issue;
   assign imem_addr = fetch_pc_q;
   assign instr_valid = cnt_q != '0;
   assign Instruction = instr_valid ? instr_mem_q[rd_ptr_q] : 16'h0000;
   assign pc_plus2 = instr_valid ? pcp2_mem_q[rd_ptr_q] : 16'h0000;
   assign halted = state_q == S_HALTED;
   assign err = err_q;
`ifdef FETCH_PERF_EN
   logic [15:0] fetch_cnt_q, squash_cnt_q;
   logic [16:0] sq_sum;
   // A response is counted as squashed once, when the redirect that kills it arrives.
   assign sq_sum = {1'b0, squash_cnt_q} + 17'(cnt_q) + 17'(state_q == S_WAIT && !squash_q);
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         squash_cnt_q <= '0;
      end else begin
         if (wr_en && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
         if (redirect) squash_cnt_q <= sq_sum[16] ? 16'hFFFF : sq_sum[15:0];
      end
   end
   assign fetch_cnt = fetch_cnt_q;
   assign squash_cnt = squash_cnt_q;
`else
   assign fetch_cnt = 16'h0000;
   assign squash_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_buffer_stage.sv
// tb_fetch_buffer_stage: randomized bench for fetch_buffer_stage against a queue-based reference model.
module tb_fetch_buffer_stage;
   localparam int DEPTH = 2;
   logic clk = 1'b0;
   logic rst, redirect, imem_rd, imem_done, instr_valid, decode_ready, halted, err;
   logic [15:0] redirect_pc, imem_addr, imem_rdata, Instruction, pc_plus2, fetch_cnt, squash_cnt;
   int checks = 0;
   int failures = 0;
   fetch_buffer_stage #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_done(imem_done), .imem_rdata(imem_rdata),
      .Instruction(Instruction), .pc_plus2(pc_plus2), .instr_valid(instr_valid),
      .decode_ready(decode_ready), .halted(halted), .err(err),
      .fetch_cnt(fetch_cnt), .squash_cnt(squash_cnt)
   );
   always #5 clk = ~clk;
   logic [31:0] q[$];
   logic [15:0] m_pc, m_req, m_fc, m_sc;
   bit m_out, m_sq, m_halt, m_err, exp_rd, exp_valid, mem_busy;
   int mem_wait;
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [15:0] sat(input int v);
      return v > 65535 ? 16'hFFFF : 16'(v);
   endfunction
   function automatic logic [15:0] gen_data(input int halt_pct);
      logic [15:0] d;
      d = 16'($urandom);
      if (int'($urandom_range(0, 99)) < halt_pct) d[15:11] = 5'b00000;
      else if (d[15:11] == 5'b00000) d[15] = 1'b1;
      return d;
   endfunction
   function automatic logic [15:0] pick_pc();
      logic [15:0] r;
      r = 16'($urandom) & 16'hFFFE;
      case ($urandom_range(0, 7))
         0: return 16'hFFFE;
         1: return 16'h0100;
         2: return 16'h0020;
         default: return r;
      endcase
   endfunction
   task automatic check_outputs();
      chk("imem_rd", 16'(imem_rd), 16'(exp_rd));
      if (exp_rd) chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", 16'(instr_valid), 16'(exp_valid));
      chk("Instruction", Instruction, exp_valid ? q[0][31:16] : 16'h0000);
      chk("pc_plus2", pc_plus2, exp_valid ? q[0][15:0] : 16'h0000);
      chk("halted", 16'(halted), 16'(m_halt));
      chk("err", 16'(err), 16'(m_err));
`ifdef FETCH_PERF_EN
      chk("fetch_cnt", fetch_cnt, m_fc);
      chk("squash_cnt", squash_cnt, m_sc);
`else
      chk("fetch_cnt", fetch_cnt, 16'h0000);
      chk("squash_cnt", squash_cnt, 16'h0000);
`endif
   endtask
   task automatic do_reset();
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = '0;
      imem_done = 1'b0;
      imem_rdata = '0;
      decode_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      q.delete();
      m_pc = 16'h0000;
      m_req = '0;
      m_fc = '0;
      m_sc = '0;
      {m_out, m_sq, m_halt, m_err, mem_busy} = '0;
      exp_rd = 1'b0;
      exp_valid = 1'b0;
      check_outputs();
      rst = 1'b0;
   endtask
   task automatic cycle(input int p_redir, input int p_ready, input int halt_pct, input bit spur);
      imem_done = 1'b0;
      imem_rdata = 16'($urandom);
      if (mem_busy) begin
         if (mem_wait == 0) begin
            imem_done = 1'b1;
            imem_rdata = gen_data(halt_pct);
            mem_busy = 1'b0;
         end else mem_wait--;
      end else if (spur && $urandom_range(0, 9) == 0) imem_done = 1'b1;
      redirect = int'($urandom_range(0, 99)) < p_redir;
      redirect_pc = pick_pc();
      decode_ready = int'($urandom_range(0, 99)) < p_ready;
      #1;
      exp_valid = q.size() > 0;
      exp_rd = !m_halt && !m_out && !redirect && q.size() < DEPTH;
      check_outputs();
      if (imem_done && !m_out) m_err = 1'b1;
      if (redirect) begin
         m_sc = sat(int'(m_sc) + q.size() + int'(m_out && !m_sq));
         q.delete();
         m_pc = redirect_pc;
         m_halt = 1'b0;
         if (m_out && !imem_done) m_sq = 1'b1;
         else begin
            m_out = 1'b0;
            m_sq = 1'b0;
         end
      end else begin
         if (exp_valid && decode_ready) void'(q.pop_front());
         if (m_out && imem_done) begin
            if (!m_sq) begin
               q.push_back({imem_rdata, m_req + 16'd2});
               m_fc = sat(int'(m_fc) + 1);
               if (imem_rdata[15:11] == 5'b00000) m_halt = 1'b1;
            end
            m_out = 1'b0;
            m_sq = 1'b0;
         end else if (exp_rd) begin
            m_out = 1'b1;
            m_req = m_pc;
            m_pc = m_pc + 16'd2;
         end
      end
      if (exp_rd) begin
         mem_busy = 1'b1;
         mem_wait = $urandom_range(0, 3);
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      do_reset();
      repeat (300) cycle(0, 100, 0, 1'b0);
      repeat (300) cycle(0, 25, 0, 1'b0);
      repeat (300) cycle(0, 70, 10, 1'b0);
      repeat (2500) cycle(8, 60, 8, 1'b0);
      do_reset();
      repeat (1500) cycle(15, 50, 10, 1'b0);
      repeat (300) cycle(5, 50, 5, 1'b1);
      do_reset();
      repeat (50) cycle(0, 100, 0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
